// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the round-robin arbiter and uart_tx.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface uart_tx_arbiter_if #(
    parameter int N_DATA = 8,
    parameter int N_REQ  = 3
);
    logic [N_REQ-1:0]        i_req;
    logic [N_REQ*N_DATA-1:0] i_req_data;
    logic [N_REQ-1:0]        o_ack;
    logic [N_REQ-1:0]        o_grant;
    logic [N_DATA-1:0]       o_tx_data;
    logic                    o_tx_start;
    logic                    i_tx_done;
    logic                    o_busy;
    logic                    o_tmo_err;

    modport slave (
        input  i_req, i_req_data, i_tx_done,
        output o_ack, o_grant, o_tx_data, o_tx_start, o_busy, o_tmo_err
    );

    modport master (
        output i_req, i_req_data, i_tx_done,
        input  o_ack, o_grant, o_tx_data, o_tx_start, o_busy, o_tmo_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte producers,
// with a watchdog that frees the channel if the transmitter never reports done.
module uart_tx_arbiter #(
    parameter int N_DATA = 8,
    parameter int N_REQ  = 3,
    parameter int NB_TMO = 18
) (
    input  logic                i_clk,
    input  logic                i_rst,
    uart_tx_arbiter_if.slave    bus
);
    localparam int                PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W:0]    N_REQ_X  = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(N_REQ - 1);
    localparam logic [NB_TMO-1:0] WD_MAX   = {NB_TMO{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_WAIT  = 2'b10
    } state_e;

    state_e             state_r, state_s;
    logic [PTR_W-1:0]   rr_ptr_r, rr_ptr_s;
    logic [NB_TMO-1:0]  wd_r, wd_s;
    logic [N_DATA-1:0]  tx_data_r, tx_data_s;
    logic               tx_start_r, tx_start_s;
    logic [N_REQ-1:0]   ack_r, ack_s;
    logic [N_REQ-1:0]   grant_r, grant_s;
    logic               busy_r, busy_s;
    logic               tmo_err_r, tmo_err_s;

    logic               win_valid_s;
    logic [PTR_W-1:0]   win_idx_s;
    logic [N_DATA-1:0]  win_data_s;
    logic [N_REQ-1:0]   win_oh_s;
    logic [PTR_W:0]     cand_s;
    logic [PTR_W-1:0]   cand_idx_s;
    logic               hit_s;
    logic               wd_term_s;

    // Rotating priority search starting at rr_ptr; first asserted request wins.
    always_comb begin
        win_valid_s = 1'b0;
        win_idx_s   = '0;
        win_data_s  = '0;
        cand_s      = '0;
        cand_idx_s  = '0;
        hit_s       = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_s      = {1'b0, rr_ptr_r} + (PTR_W+1)'(i);
            cand_s      = (cand_s >= N_REQ_X) ? (cand_s - N_REQ_X) : cand_s;
            cand_idx_s  = cand_s[PTR_W-1:0];
            hit_s       = bus.i_req[cand_idx_s] & ~win_valid_s;
            win_idx_s   = hit_s ? cand_idx_s : win_idx_s;
            win_data_s  = hit_s ? bus.i_req_data[int'(cand_idx_s)*N_DATA +: N_DATA] : win_data_s;
            win_valid_s = win_valid_s | hit_s;
        end
        win_oh_s = N_REQ'(1'b1) << win_idx_s;
    end

    assign wd_term_s = (wd_r == WD_MAX);

    // Next-state logic; a done pulse takes priority over the watchdog terminal count.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = win_valid_s ? ST_START : ST_IDLE;
            ST_START: state_s = ST_WAIT;
            ST_WAIT: begin
                if (bus.i_tx_done) begin
                    state_s = ST_IDLE;
                end else if (wd_term_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default:  state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and watchdog.
    always_comb begin
        rr_ptr_s   = rr_ptr_r;
        wd_s       = wd_r;
        tx_data_s  = tx_data_r;
        tx_start_s = 1'b0;
        ack_s      = '0;
        grant_s    = grant_r;
        busy_s     = (state_s != ST_IDLE);
        tmo_err_s  = tmo_err_r;
        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    tx_data_s  = win_data_s;
                    tx_start_s = 1'b1;
                    ack_s      = win_oh_s;
                    grant_s    = win_oh_s;
                    rr_ptr_s   = (win_idx_s == LAST_IDX) ? '0 : (win_idx_s + PTR_W'(1'b1));
                end else begin
                    grant_s    = '0;
                end
            end
            ST_START: wd_s = '0;
            ST_WAIT: begin
                if (bus.i_tx_done) begin
                    grant_s   = '0;
                end else if (wd_term_s) begin
                    grant_s   = '0;
                    tmo_err_s = 1'b1;
                end else begin
                    wd_s      = wd_r + NB_TMO'(1'b1);
                end
            end
            default: grant_s = '0;
        endcase
    end

    // State, pointer, watchdog and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            wd_r       <= '0;
            tx_data_r  <= '0;
            tx_start_r <= 1'b0;
            ack_r      <= '0;
            grant_r    <= '0;
            busy_r     <= 1'b0;
            tmo_err_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            rr_ptr_r   <= rr_ptr_s;
            wd_r       <= wd_s;
            tx_data_r  <= tx_data_s;
            tx_start_r <= tx_start_s;
            ack_r      <= ack_s;
            grant_r    <= grant_s;
            busy_r     <= busy_s;
            tmo_err_r  <= tmo_err_s;
        end
    end

    assign bus.o_tx_data  = tx_data_r;
    assign bus.o_tx_start = tx_start_r;
    assign bus.o_ack      = ack_r;
    assign bus.o_grant    = grant_r;
    assign bus.o_busy     = busy_r;
    assign bus.o_tmo_err  = tmo_err_r;
endmodule
